// File: rtl/pio_sample_pkg.sv
// Shared definitions for the periodic PIO sampler: FSM state encoding,
// the PIO data-register address and the sample word width.
package pio_sample_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic [1:0] PIO_DATA_ADDR = 2'd0;
    localparam int         DATA_W        = 32;

endpackage

// File: rtl/pio_sample_fifo.sv
// Show-ahead sample FIFO. Pointers carry one extra wrap bit so that
// full (same index, different wrap) and empty (identical) are distinct.
// A push into a full FIFO is accepted only when a pop happens on the same
// edge; otherwise it is dropped and the caller flags the loss.
module pio_sample_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign valid   = (wr_ptr != rd_ptr);
    assign fill    = wr_ptr - rd_ptr;
    assign full    = (fill == FULL_LEVEL);
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);
    // Empty FIFO presents zero so the head is defined straight out of reset.
    assign head    = valid ? mem[rd_ptr[AW-1:0]] : '0;

    // Storage write; contents need no reset because valid gates the head.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= data;
        end
    end

    // Pointer update for accepted pushes and non-empty pops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
        end
    end

endmodule

// File: rtl/pio_sample_master.sv
// Periodic Avalon-MM PIO sampler. Every SAMPLE_DIV cycles of enable it
// issues one read (latency 1, no waitrequest) and buffers the word in a
// show-ahead FIFO. Optional macro PIO_SAMPLE_CHANGE_ONLY_EN suppresses
// pushes of a word equal to the last pushed one.
// Output handshake: a sample leaves the FIFO on a rising edge where
// out_valid and out_ready are both high; out_data is held otherwise.
module pio_sample_master
    import pio_sample_pkg::*;
#(
    parameter int SAMPLE_DIV = 1000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    output logic [1:0]                   avm_address,
    output logic                         avm_read,
    input  logic [31:0]                  avm_readdata,
    output logic [31:0]                  out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(FIFO_DEPTH):0]  fill,
    output logic                         overflow,
    input  logic                         ovf_clr
);

    localparam int CNT_W = $clog2(SAMPLE_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             tick;
    state_t           state;
    state_t           state_next;
    logic             capture;
    logic             push_req;
    logic             full;
    logic             drop;

    assign tick        = enable && (cnt == CNT_LAST);
    assign avm_read    = (state == ISSUE);
    assign avm_address = PIO_DATA_ADDR;
    assign capture     = (state == CAPTURE);

    // Sample-period counter; parked at zero while sampling is disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          cnt <= '0;
        else if (!enable)   cnt <= '0;
        else if (tick)      cnt <= '0;
        else                cnt <= cnt + CNT_W'(1);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // FSM next state: a started read always runs to capture, even if
    // enable drops, so no transaction is left half done.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (tick) state_next = ISSUE;
            ISSUE:   state_next = CAPTURE;
            CAPTURE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef PIO_SAMPLE_CHANGE_ONLY_EN
    logic [31:0] last_word;
    logic        have_word;

    assign push_req = capture && (!have_word || (avm_readdata != last_word));

    // Remember the last word offered to the FIFO, even if it was dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_word <= '0;
            have_word <= 1'b0;
        end else if (push_req) begin
            last_word <= avm_readdata;
            have_word <= 1'b1;
        end
    end
`else
    assign push_req = capture;
`endif

    assign drop = push_req && full && !(out_valid && out_ready);

    // Sticky overflow; a new drop wins over a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        overflow <= 1'b0;
        else if (drop)    overflow <= 1'b1;
        else if (ovf_clr) overflow <= 1'b0;
    end

    pio_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .data  (avm_readdata),
        .pop   (out_ready),
        .head  (out_data),
        .valid (out_valid),
        .fill  (fill),
        .full  (full)
    );

endmodule

// File: tb/tb_pio_sample_master.sv
// Self-checking bench for pio_sample_master (SAMPLE_DIV=4, FIFO_DEPTH=4).
// Honours PIO_SAMPLE_CHANGE_ONLY_EN when defined for the build.
module tb_pio_sample_master;

    localparam int DIV   = 4;
    localparam int DEPTH = 4;
    localparam int FW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [1:0]    avm_address;
    logic          avm_read;
    logic [31:0]   avm_readdata;
    logic [31:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic [FW-1:0] fill;
    logic          overflow;
    logic          ovf_clr;

    // ---------------- clock / reset block ----------------
    always #5 clk = ~clk;

    pio_sample_master #(
        .SAMPLE_DIV (DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .avm_address  (avm_address),
        .avm_read     (avm_read),
        .avm_readdata (avm_readdata),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .fill         (fill),
        .overflow     (overflow),
        .ovf_clr      (ovf_clr)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    // Samples are a queue; a tick falls on every DIV-th cycle of an
    // unbroken enable run, the read one cycle later, the capture one after.
    logic [31:0] exp_q[$];
    int          cyc = 0;
    int          read_at;
    int          cap_at;
    int          en_run;
    logic        ovf_m;
    logic [31:0] last_m;
    bit          have_m;

    task automatic model_clear();
        exp_q.delete();
        read_at = -1;
        cap_at  = -1;
        en_run  = 0;
        ovf_m   = 1'b0;
        have_m  = 1'b0;
        last_m  = '0;
    endtask

    task automatic model_step();
        bit          do_pop;
        bit          want_push;
        bit          set_ovf;
        logic [31:0] d;
        if (reset) begin
            model_clear();
        end else begin
            do_pop    = out_ready && (exp_q.size() > 0);
            want_push = (cyc == cap_at);
            d         = avm_readdata;
            set_ovf   = 1'b0;
`ifdef PIO_SAMPLE_CHANGE_ONLY_EN
            if (want_push) begin
                if (have_m && d == last_m) want_push = 1'b0;
                else begin
                    last_m = d;
                    have_m = 1'b1;
                end
            end
`endif
            if (do_pop) void'(exp_q.pop_front());
            if (want_push) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(d);
                else set_ovf = 1'b1;
            end
            if (set_ovf)      ovf_m = 1'b1;
            else if (ovf_clr) ovf_m = 1'b0;
            if (cyc == read_at) cap_at = cyc + 1;
            if (enable) begin
                if (en_run % DIV == DIV - 1) read_at = cyc + 1;
                en_run++;
            end else begin
                en_run = 0;
            end
        end
        cyc++;
    endtask

    task automatic compare();
        check("avm_read", 32'(avm_read), 32'(cyc == read_at));
        check("avm_address", 32'(avm_address), 32'd0);
        check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
        check("fill", 32'(fill), 32'(exp_q.size()));
        check("overflow", 32'(overflow), 32'(ovf_m));
        if (exp_q.size() > 0)  check("out_data", out_data, exp_q[0]);
        else if (reset)        check("out_data_rst", out_data, 32'd0);
    endtask

    // ---------------- driver ----------------
    logic        seen_read;
    logic        seen_valid;
    logic        seen_ovf;
    logic [31:0] seen_data;
    logic [31:0] seen_fill;

    task automatic run_cycle(input logic en, input logic rdy, input logic clr,
                             input logic rst, input logic [31:0] pio);
        enable       = en;
        out_ready    = rdy;
        ovf_clr      = clr;
        avm_readdata = pio;
        reset        = rst;
        if (rst) model_clear();
        @(negedge clk);
        compare();
        seen_read  = avm_read;
        seen_valid = out_valid;
        seen_ovf   = overflow;
        seen_data  = out_data;
        seen_fill  = 32'(fill);
        @(posedge clk);
        model_step();
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] samples[$];
        logic [31:0] newest;
        int          cnt_a;
        int          cnt_b;
        int          k;
        bit          found;
        logic        r_en;

        model_clear();
        repeat (3) run_cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        check("rst_fill", seen_fill, 32'd0);
        check("rst_valid", 32'(seen_valid), 32'd0);

        // Basic timing: reads every DIV cycles, one-cycle valid pulses.
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 20; i++) begin
            run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h1234_5678);
            cnt_a += int'(seen_read);
            cnt_b += int'(seen_valid);
        end
        check("basic_reads", 32'(cnt_a), 32'd4);
        check("basic_valid_pulses", 32'(cnt_b), 32'd4);

        // Overflow: six ticks into a depth-4 FIFO with no consumer.
        run_cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        samples.delete();
        for (int i = 0; i < 27; i++) begin
            logic [31:0] v;
            v = $urandom;
            if (cyc == cap_at && samples.size() < DEPTH) samples.push_back(v);
            run_cycle(1'b1, 1'b0, 1'b0, 1'b0, v);
        end
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check("ovf_fill", seen_fill, 32'(DEPTH));
        check("ovf_flag", 32'(seen_ovf), 32'd1);
        check("ovf_head", seen_data, samples[0]);
        run_cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check("ovf_cleared", 32'(seen_ovf), 32'd0);

        // Full boundary: pop on the capture cycle of a full FIFO.
        newest = 32'd0;
        for (int i = 0; i < 7; i++) begin
            logic [31:0] v;
            logic        rdy;
            v   = $urandom;
            rdy = (cyc == cap_at);
            if (rdy) newest = v;
            run_cycle(1'b1, rdy, 1'b0, 1'b0, v);
        end
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check("full_pp_fill", seen_fill, 32'(DEPTH));
        check("full_pp_ovf", 32'(seen_ovf), 32'd0);
        samples.push_back(newest);
        for (int i = 1; i <= DEPTH; i++) begin
            run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
            check("full_pp_order", seen_data, samples[i]);
        end
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check("full_pp_drained", 32'(seen_valid), 32'd0);

        // Reset pulsed while the FSM is in CAPTURE.
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cyc == cap_at) begin
                found = 1'b1;
                break;
            end
            run_cycle(1'b1, 1'b1, 1'b0, 1'b0, $urandom);
        end
        check("rst_mid_reached_capture", 32'(found), 32'd1);
        run_cycle(1'b1, 1'b1, 1'b0, 1'b1, $urandom);
        k = 0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
            if (i == 0) begin
                check("rst_mid_fill", seen_fill, 32'd0);
                check("rst_mid_valid", 32'(seen_valid), 32'd0);
            end
            if (seen_read) begin
                found = 1'b1;
                break;
            end
            k++;
        end
        check("rst_mid_read_seen", 32'(found), 32'd1);
        check("rst_mid_latency", 32'(k), 32'(DIV));

        // Change-only filter: five ticks of 0xA5 then one of 0x5A.
        run_cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        for (int i = 0; i < 27; i++) begin
            run_cycle(1'b1, 1'b0, 1'b0, 1'b0, (i < 22) ? 32'hA5 : 32'h5A);
        end
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
`ifdef PIO_SAMPLE_CHANGE_ONLY_EN
        check("chg_fill", seen_fill, 32'd2);
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        check("chg_first", seen_data, 32'hA5);
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        check("chg_second", seen_data, 32'h5A);
`else
        check("chg_fill", seen_fill, 32'(DEPTH));
        check("chg_ovf", 32'(seen_ovf), 32'd1);
`endif
        repeat (5) run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);

        // Randomized traffic against the model.
        r_en = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) r_en = ~r_en;
            run_cycle(r_en,
                      1'($urandom_range(0, 2) == 0),
                      1'($urandom_range(0, 15) == 0),
                      1'($urandom_range(0, 99) == 0),
                      32'($urandom_range(0, 3)));
        end

        // ---------------- final report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
